// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the arbitrated ALU slice: FSM state encoding,
//   3-bit ALUOp constants and a helper that flags out-of-range shifts.
//   No ports; imported by alu and alu_arbiter.
package alu_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ALUOp encoding; 110 and 111 are reserved and produce zero
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;

  // The whole 32-bit B is the shift amount, so anything >= 32 shifts
  // every bit of A out.
  function automatic logic shift_oob(input logic [DATA_W-1:0] amt);
    return (amt >= 32'd32);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu
//   Combinational 32-bit ALU.
//   Ports:
//     a, b : input  [31:0] operands (b is also the shift amount)
//     op   : input  [2:0]  ALUOp
//     c    : output [31:0] result
module alu
  import alu_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] c
);

  always_comb begin
    c = '0;
    case (op)
      OP_ADD: c = a + b;
      OP_SUB: c = a - b;
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      // Only the low 5 bits select the in-range shift; larger amounts
      // saturate to all-zero or all-sign.
      OP_SRL: c = shift_oob(b) ? '0 : (a >> b[4:0]);
      OP_SRA: c = shift_oob(b) ? {DATA_W{a[DATA_W-1]}}
                               : DATA_W'($signed(a) >>> b[4:0]);
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two requesters share one ALU through an IDLE -> EXEC -> RESP FSM with
//   round-robin arbitration (1-bit pointer, requester 0 favoured after reset).
//   Ports:
//     clk, reset                 : clock (rising edge), async active-high reset
//     reqN_valid/_a/_b/_op       : requester N operation (N = 0, 1)
//     reqN_ready                 : requester N accepted this cycle (IDLE only)
//     rsp_valid, rsp_c, rsp_id   : result, owner of the result
//     rsp_ready                  : consumer takes the result
module alu_arbiter
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              req1_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_c,
  output logic              rsp_id
);

  logic [1:0]        state_q;
  logic              ptr_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic              id_q;
  logic [DATA_W-1:0] alu_c;
  logic              idle;
  logic              grant0;
  logic              grant1;

  // Requester 1 wins when it is alone or when the pointer favours it on a
  // tie; requester 0 wins every other valid case, so the two are exclusive.
  // Readies are gated with reset so they drop without waiting for a clock.
  assign idle       = (state_q == ST_IDLE) && !reset;
  assign grant1     = req1_valid && (!req0_valid || ptr_q);
  assign grant0     = req0_valid && !grant1;
  assign req0_ready = idle && grant0;
  assign req1_ready = idle && grant1;

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;

  alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .c  (alu_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      rsp_c   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            a_q     <= grant1 ? req1_a  : req0_a;
            b_q     <= grant1 ? req1_b  : req0_b;
            op_q    <= grant1 ? req1_op : req0_op;
            id_q    <= grant1;
            // Hand priority to whichever requester did not just win.
            ptr_q   <= !grant1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_c   <= alu_c;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Self-checking bench: stimulus pushes expected {id, result} into a
//   scoreboard queue; a negedge monitor pops and compares on each response
//   handshake, and also watches ready exclusivity and response stability.
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] c;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_op;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_op;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_c;
  logic        rsp_id;

  int   tests;
  int   fails;
  bit   model_ptr;
  exp_t expq[$];

  logic        stall_prev;
  logic [31:0] prev_c;
  logic        prev_id;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_c      (rsp_c),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU written from the arithmetic rules: an arithmetic right
  // shift of a negative value is the complement of a logical shift of its
  // complement, and SV logical shifts by >= 32 already give zero.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (b >= 32) ? 32'd0 : (a >> b);
      3'd5: return a[31] ? ~((~a) >> b) : (a >> b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic randomizeRequests();
    req0_valid = 1'($urandom_range(0, 1));
    req1_valid = 1'($urandom_range(0, 1));
    req0_a     = $urandom;
    req0_b     = $urandom;
    req0_op    = 3'($urandom_range(0, 7));
    req1_a     = $urandom;
    req1_b     = $urandom;
    req1_op    = 3'($urandom_range(0, 7));
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a
  // rising edge with the DUT idle again. hold = extra RESP cycles with
  // rsp_ready low (one stalled cycle is always present).
  task automatic applyStimulus(input bit v0, input bit v1,
                               input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                               input int hold);
    bit   w;
    exp_t e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = 1'b0;
    w = (v0 && v1) ? model_ptr : v1;
    @(negedge clk);
    checkOutput("req0_ready_grant", 32'(req0_ready), 32'(w == 1'b0));
    checkOutput("req1_ready_grant", 32'(req1_ready), 32'(w == 1'b1));
    e.id = w;
    e.c  = w ? alu_model(a1, b1, op1) : alu_model(a0, b0, op0);
    expq.push_back(e);
    model_ptr = ~w;
    @(posedge clk); #1;
    randomizeRequests();
    rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkOutput("rsp_valid_exec", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    repeat (hold) begin
      @(posedge clk); #1;
      randomizeRequests();
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge clk); #1;
    rsp_ready  = 1'b0;
  endtask

  // Scoreboard monitor plus per-cycle protocol checks.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_prev <= 1'b0;
    end else begin
      checkOutput("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
      if (rsp_valid) begin
        checkOutput("ready_during_resp", 32'(req0_ready | req1_ready), 32'd0);
        if (stall_prev) begin
          checkOutput("rsp_c_stable", rsp_c, prev_c);
          checkOutput("rsp_id_stable", 32'(rsp_id), 32'(prev_id));
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          checkOutput("rsp_c", rsp_c, e.c);
          checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
      stall_prev <= rsp_valid && !rsp_ready;
      prev_c     <= rsp_c;
      prev_id    <= rsp_id;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit v0;
    bit v1;
    bit w;
    exp_t e;
    logic [31:0] b0;
    logic [31:0] b1;
    tests      = 0;
    fails      = 0;
    model_ptr  = 1'b0;
    stall_prev = 1'b0;
    prev_c     = '0;
    prev_id    = 1'b0;

    // Reset values, with both requesters valid to show readies are forced low
    reset      = 1'b1;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'd0;
    #3;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_c", rsp_c, 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("reset_req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases
    applyStimulus(1, 0, 32'h5, 32'h3, 3'b001, 32'h0, 32'h0, 3'b000, 0);
    applyStimulus(0, 1, 32'h0, 32'h0, 3'b000, 32'h8000_0000, 32'd4, 3'b101, 0);
    applyStimulus(0, 1, 32'h0, 32'h0, 3'b000, 32'h8000_0000, 32'd4, 3'b100, 0);
    applyStimulus(0, 1, 32'h0, 32'h0, 3'b000, 32'h8000_0000, 32'd40, 3'b100, 0);
    applyStimulus(0, 1, 32'h0, 32'h0, 3'b000, 32'h8000_0000, 32'd40, 3'b101, 1);
    applyStimulus(1, 0, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'h0, 32'h0, 3'b000, 0);
    applyStimulus(1, 0, $urandom, $urandom, 3'b110, 32'h0, 32'h0, 3'b000, 0);
    applyStimulus(1, 1, 32'h1234, 32'h1, 3'b011, $urandom, $urandom, 3'b111, 0);
    applyStimulus(1, 1, 32'hDEAD_BEEF, 32'hFFFF, 3'b010, 32'h10, 32'h20, 3'b001, 5);

    // Continuous contention with rsp_ready high: grants alternate every 3 cycles
    req0_valid = 1'b1; req0_a = 32'd100;     req0_b = 32'd1;      req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 32'h0F0F;    req1_b = 32'h00FF;   req1_op = 3'b010;
    rsp_ready  = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (cyc % 3 == 0) begin
        w = model_ptr;
        checkOutput("contend_req0_ready", 32'(req0_ready), 32'(w == 1'b0));
        checkOutput("contend_req1_ready", 32'(req1_ready), 32'(w == 1'b1));
        e.id = w;
        e.c  = w ? alu_model(32'h0F0F, 32'h00FF, 3'b010) : alu_model(32'd100, 32'd1, 3'b001);
        expq.push_back(e);
        model_ptr = ~w;
      end else begin
        checkOutput("contend_gap_ready", 32'(req0_ready | req1_ready), 32'd0);
      end
      @(posedge clk); #1;
      if (cyc == 10) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    rsp_ready = 1'b0;

    // Reset during EXEC: the operation vanishes, outputs drop immediately
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9; req0_op = 3'b000;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_rsp_c", rsp_c, 32'd0);
    checkOutput("midreset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("midreset_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("midreset_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    model_ptr = 1'b0;
    applyStimulus(1, 1, 32'd7, 32'd9, 3'b000, 32'd50, 32'd8, 3'b001, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      b0 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      b1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      applyStimulus(v0, v1, $urandom, b0, 3'($urandom_range(0, 7)),
                    $urandom, b1, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drain", 32'(expq.size()), 32'd0);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
